// File: rtl/dmem_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit and its helpers.
package dmem_access_unit_pkg;

   // Memory-stage transaction states
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StDone = 2'd2
   } dmem_state_t;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

   // Timeout counter width; TIMEOUT must fit (1..2^16-1)
   localparam int unsigned TIMEOUT_CTR_W = 16;

   // Low address bits dropped to form a word address
   localparam int unsigned WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Clear/enable counter with a terminal-count flag at TIMEOUT-1.
// Shared between the data-memory and instruction-fetch bus masters.
module dmem_timeout_ctr
   import dmem_access_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [TIMEOUT_CTR_W-1:0] TermCount = TIMEOUT_CTR_W'(TIMEOUT - 1);

   logic [TIMEOUT_CTR_W-1:0] count_q;

   // Count register: clear wins over enable
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign terminal = (count_q == TermCount);

endmodule

// File: rtl/dmem_access_unit.sv
// Memory stage: turns lw/sw control plus the ALU address into one valid/ready
// bus transaction, stalling the core until it completes or times out.
module dmem_access_unit
   import dmem_access_unit_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   input  logic          memread,
   input  logic          memwrite,
   output logic          stall,
   output logic [DW-1:0] rdata,
   output logic          misalign,
   output logic          ctl_err,
   output logic          bus_err,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_ready,
   input  logic [DW-1:0] bus_rdata
);

   dmem_state_t   state_q, state_d;
   logic          bus_req_q;
   logic          bus_we_q;
   logic [AW-1:0] bus_addr_q;
   logic [DW-1:0] bus_wdata_q;
   logic [DW-1:0] rdata_q;
   logic          bus_err_q;

   logic access;
   logic aligned;
   logic ok;
   logic in_req;
   logic tmo_term;
   logic abort;
   logic finish;

   assign access  = memread ^ memwrite;
   assign aligned = (addr[WORD_OFFSET_BITS-1:0] == '0);
   assign ok      = access && aligned;
   assign in_req  = (state_q == StReq);

   // Ready on the terminal cycle still counts as a normal completion
   assign abort  = in_req && !bus_ready && tmo_term;
   assign finish = in_req && (bus_ready || tmo_term);

   dmem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk      (clk),
      .reset    (reset),
      .clear    (!in_req || bus_ready),
      .enable   (in_req),
      .terminal (tmo_term)
   );

   // Next-state and combinational handshake/error outputs
   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      misalign = 1'b0;
      ctl_err  = 1'b0;
      case (state_q)
         StIdle: begin
            if (ok) begin
               stall   = 1'b1;
               state_d = StReq;
            end else if (!reset && memread && memwrite) begin
               ctl_err = 1'b1;
            end else if (!reset && access) begin
               misalign = 1'b1;
            end
         end
         StReq: begin
            stall = 1'b1;
            if (finish) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Bus-side registers, load-data capture and timeout error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         rdata_q     <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         bus_err_q <= abort;
         if (state_q == StIdle && ok) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= memwrite;
            bus_addr_q  <= {addr[AW-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
            bus_wdata_q <= wdata;
         end
         if (finish) begin
            bus_req_q <= 1'b0;
            // Stores leave the last load value untouched
            if (!bus_we_q) begin
               rdata_q <= bus_ready ? bus_rdata : '0;
            end
         end
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign rdata     = rdata_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a short timeout so aborts are quick.
module tb_dmem_access_unit;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        memread;
   logic        memwrite;
   logic        stall;
   logic [31:0] rdata;
   logic        misalign;
   logic        ctl_err;
   logic        bus_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int checks;
   int failures;

   int   n_stall;
   int   n_req;
   logic stable;

   dmem_access_unit #(
      .AW      (32),
      .DW      (32),
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .memread   (memread),
      .memwrite  (memwrite),
      .stall     (stall),
      .rdata     (rdata),
      .misalign  (misalign),
      .ctl_err   (ctl_err),
      .bus_err   (bus_err),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ready (bus_ready),
      .bus_rdata (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one access from IDLE; the slave raises ready after 'waits' REQ cycles.
   // Returns in the DONE cycle with the core-side controls dropped.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_baddr,
                            input int waits, input logic [31:0] rdat,
                            output int stall_cyc, output int req_cyc, output logic stab);
      logic hung;
      hung      = 1'b1;
      stall_cyc = 0;
      req_cyc   = 0;
      stab      = 1'b1;
      memread   = rd;
      memwrite  = wr;
      addr      = a;
      wdata     = wd;
      bus_ready = 1'b0;
      bus_rdata = rdat;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (!stall) begin
            hung = 1'b0;
            break;
         end
         stall_cyc++;
         if (bus_req) begin
            req_cyc++;
            if (bus_addr !== exp_baddr || bus_wdata !== wd || bus_we !== wr) stab = 1'b0;
         end
         bus_ready = bus_req && (req_cyc == waits + 1);
         tick();
      end
      check("no_hang", {31'd0, hung}, 32'd0);
      memread   = 1'b0;
      memwrite  = 1'b0;
      bus_ready = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      addr      = '0;
      wdata     = '0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      bus_ready = 1'b0;
      bus_rdata = '0;
      tick();
      tick();
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_bus_we", {31'd0, bus_we}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_errs", {29'd0, misalign, ctl_err, bus_err}, 32'd0);
      reset = 1'b0;
      tick();

      // lw 0x10, ready in the first REQ cycle
      do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0010, 0, 32'hCAFE_F00D,
                n_stall, n_req, stable);
      check("lw1_stall_cycles", n_stall, 2);
      check("lw1_req_cycles", n_req, 1);
      check("lw1_bus_stable", {31'd0, stable}, 32'd1);
      check("lw1_rdata", rdata, 32'hCAFE_F00D);
      check("lw1_done_req", {31'd0, bus_req}, 32'd0);
      tick();

      // bus_ready outside REQ is ignored
      bus_ready = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      tick();
      bus_ready = 1'b0;
      check("idle_ready_req", {31'd0, bus_req}, 32'd0);
      check("idle_ready_rdata", rdata, 32'hCAFE_F00D);

      // sw 0x24 with 3 wait cycles; ready lands on the terminal count
      do_access(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 32'h0000_0024, 3, 32'h0BAD_0BAD,
                n_stall, n_req, stable);
      check("sw_stall_cycles", n_stall, 5);
      check("sw_req_cycles", n_req, 4);
      check("sw_bus_stable", {31'd0, stable}, 32'd1);
      check("sw_rdata_kept", rdata, 32'hCAFE_F00D);
      check("sw_no_bus_err", {31'd0, bus_err}, 32'd0);
      tick();

      // Misaligned lw
      memread = 1'b1;
      addr    = 32'h0000_0013;
      #1;
      check("mis_pulse", {31'd0, misalign}, 32'd1);
      check("mis_stall", {31'd0, stall}, 32'd0);
      check("mis_ctl_err", {31'd0, ctl_err}, 32'd0);
      tick();
      memread = 1'b0;
      #1;
      check("mis_pulse_end", {31'd0, misalign}, 32'd0);
      check("mis_no_req", {31'd0, bus_req}, 32'd0);

      // Illegal memread & memwrite
      memread  = 1'b1;
      memwrite = 1'b1;
      addr     = 32'h0000_0040;
      #1;
      check("ctl_pulse", {31'd0, ctl_err}, 32'd1);
      check("ctl_stall", {31'd0, stall}, 32'd0);
      tick();
      memread  = 1'b0;
      memwrite = 1'b0;
      #1;
      check("ctl_pulse_end", {31'd0, ctl_err}, 32'd0);
      check("ctl_no_req", {31'd0, bus_req}, 32'd0);

      // lw with ready stuck low: aborts after TIMEOUT=4 REQ cycles
      do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0000_0030, 100, 32'h7777_7777,
                n_stall, n_req, stable);
      check("tmo_req_cycles", n_req, 4);
      check("tmo_stall_cycles", n_stall, 5);
      check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
      check("tmo_rdata", rdata, 32'd0);
      tick();
      check("tmo_bus_err_end", {31'd0, bus_err}, 32'd0);

      // Reset in the second REQ cycle
      memread = 1'b1;
      addr    = 32'h0000_0008;
      tick();
      tick();
      check("rreq_req2", {31'd0, bus_req}, 32'd1);
      reset = 1'b1;
      tick();
      memread = 1'b0;
      #1;
      check("rreq_req_drop", {31'd0, bus_req}, 32'd0);
      check("rreq_stall", {31'd0, stall}, 32'd0);
      check("rreq_no_err", {31'd0, bus_err}, 32'd0);
      reset = 1'b0;
      tick();
      check("rreq_no_err2", {31'd0, bus_err}, 32'd0);
      check("rreq_no_retry", {31'd0, bus_req}, 32'd0);
      do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0020, 0, 32'h0000_55AA,
                n_stall, n_req, stable);
      check("rreq_lw_stall", n_stall, 2);
      check("rreq_lw_rdata", rdata, 32'h0000_55AA);
      tick();

      // Back-to-back lw 0x0 then 0x4
      do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0, 32'h1111_1111,
                n_stall, n_req, stable);
      check("b2b0_stall", n_stall, 2);
      check("b2b0_stable", {31'd0, stable}, 32'd1);
      check("b2b0_rdata", rdata, 32'h1111_1111);
      tick();
      do_access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0004, 0, 32'h2222_2222,
                n_stall, n_req, stable);
      check("b2b1_stall", n_stall, 2);
      check("b2b1_req", n_req, 1);
      check("b2b1_stable", {31'd0, stable}, 32'd1);
      check("b2b1_rdata", rdata, 32'h2222_2222);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory stage directly downstream of the ALU in the single-cycle core.
- Takes the ALU result as a byte address, plus store data and lw/sw control, and runs a valid/ready transaction on the data bus.
- Freezes the core via `stall` while the bus is slow, then presents the load data to writeback.
- Flags misaligned accesses, illegal control combinations and bus timeouts.

Parameters:
- AW, 32, address width (equals ALU result width)
- DW, 32, data width
- TIMEOUT, 255, max REQ cycles waiting for bus_ready before abort (1..2^16-1)

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- addr  in  AW  ALU result, byte address
- wdata  in  DW  store data (rt)
- memread  in  1  lw in this instruction
- memwrite  in  1  sw in this instruction
- stall  out  1  hold PC/regfile write; instruction not complete this cycle
- rdata  out  DW  load data, valid in the cycle stall falls for a load
- misalign  out  1  one-cycle pulse: addr[1:0]!=0 on access
- ctl_err  out  1  one-cycle pulse: memread&memwrite both high
- bus_err  out  1  one-cycle pulse: timeout abort
- bus_req  out  1  transaction valid
- bus_we  out  1  1=write, 0=read
- bus_addr  out  AW  word-aligned address {addr[AW-1:2],2'b00}, registered
- bus_wdata  out  DW  registered store data
- bus_ready  in  1  slave accepts/completes this cycle
- bus_rdata  in  DW  read data, valid when bus_ready high with bus_we=0

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata, rdata, the timeout counter and all error pulses clear to 0.
  - stall=0 provided memread=memwrite=0.
- States: IDLE, REQ, DONE.
- access = memread ^ memwrite; ok = access & (addr[1:0]==0).
- IDLE:
  - If ok: latch addr/wdata/we into the bus registers and go to REQ. stall=1 combinationally in this cycle.
  - If access but misaligned: misalign=1 for one cycle. No bus activity, stall=0, rdata unchanged. The store is suppressed.
  - If memread&memwrite: ctl_err=1 for one cycle. No access, stall=0.
  - If no access: stall=0.
- REQ:
  - bus_req=1 and stall=1. bus_addr, bus_we and bus_wdata are held stable.
  - The counter increments each cycle.
  - On bus_ready=1: drop bus_req at the next edge, capture bus_rdata into rdata (loads only), clear the counter, go to DONE.
  - If the counter reaches TIMEOUT-1 with no ready: abort to DONE, rdata=0, bus_err pulses in the DONE cycle.
  - Latency with ready in the first REQ cycle: 2 stall cycles. Each wait cycle adds 1.
- DONE:
  - stall=0, bus_req=0, rdata valid. The core retires the instruction at this edge.
  - Always goes to IDLE next; a new access is evaluated there.
  - Back-to-back accesses therefore cost 3 cycles each (with immediate ready).
- bus_ready outside REQ is ignored.
- Inputs changing during REQ are ignored; they are legal because the core is stalled.
- Reset during REQ: bus_req=0 after that edge, no retry, no error pulse.
- Reset has priority over every other event in the same cycle.
- rdata holds its last value until the next completed load. Stores do not modify it.

Decomposition:
- Shared package/header (common.svh): add
  - the dmem_state_t enum {IDLE, REQ, DONE}
  - `MEM_TIMEOUT_DEFAULT`
  - the word-align mask macro.
- Sub-module dmem_timeout_ctr: clear/enable/terminal-count counter parameterised by TIMEOUT. It is natural to separate so it can be reused by the instruction-fetch side.
- The FSM and datapath registers stay in dmem_access_unit.

Test Plan:
- lw addr=0x0000_0010, bus_ready in the 1st REQ cycle with bus_rdata=0xCAFE_F00D -> stall high 2 cycles, bus_addr=0x10, bus_we=0, rdata=0xCAFE_F00D when stall falls.
- sw addr=0x0000_0024, wdata=0x1234_5678, ready after 3 waits -> bus_req held 4 cycles with stable addr/wdata, bus_we=1, stall 5 cycles, rdata unchanged.
- lw addr=0x0000_0013 -> misalign pulse 1 cycle, bus_req never asserts, stall=0.
- memread=memwrite=1 -> ctl_err pulse, no bus_req. Separately, TIMEOUT=4 with bus_ready stuck 0 -> bus_req 4 cycles, bus_err pulse, rdata=0, stall falls.
- reset asserted in the 2nd REQ cycle -> next edge bus_req=0, state IDLE, no bus_err. A following lw completes normally.
- Two consecutive lw (0x0 then 0x4) with immediate ready -> two distinct transactions, 3 cycles each, correct rdata for each.
